// File: rtl/mvau_defn.sv
// rtl/mvau_defn.sv - shared widths and helpers for the MVU processing element
// Purpose: default PE geometry and adder-tree growth helper.
// Ports: none (package).
package mvau_defn;

  localparam int SIMD_DEF  = 4;   // product lanes per beat
  localparam int SF_DEF    = 3;   // beats per output (synapse fold)
  localparam int TDSTI_DEF = 4;   // signed product lane width
  localparam int TDST_DEF  = 16;  // accumulator / output width

  // Extra bits a full reduction of simd signed lanes can grow by.
  function automatic int tree_growth(input int simd);
    return $clog2(simd);
  endfunction

endpackage

// File: rtl/mvu_pe_acc_if.sv
// rtl/mvu_pe_acc_if.sv - beat input and result output handshake bundle
// Purpose: groups the product-beat stream and the result stream of the PE accumulator.
// Ports: in_v/in_rdy/in_simd (beat stream), out_v/out_rdy/out (result stream).
//   master: producer of beats and consumer of results; slave: the accumulator.
interface mvu_pe_acc_if
  import mvau_defn::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int TDst  = TDST_DEF
);

  logic                  in_v;
  logic                  in_rdy;
  logic [SIMD*TDstI-1:0] in_simd;
  logic                  out_v;
  logic                  out_rdy;
  logic [TDst-1:0]       out;

  modport master (
    output in_v, in_simd, out_rdy,
    input  in_rdy, out_v, out
  );

  modport slave (
    input  in_v, in_simd, out_rdy,
    output in_rdy, out_v, out
  );

endinterface

// File: rtl/mvu_pe_adders.sv
// rtl/mvu_pe_adders.sv - registered signed reduction of SIMD product lanes
// Purpose: sums SIMD signed lanes into one TDst-bit partial sum, 1-cycle latency.
// Ports: clk, rst (sync, active-high), en (stage advance), in_v/in_simd (beat),
//   s1_v/s1_sum (registered valid and partial sum; both hold while !en).
module mvu_pe_adders
  import mvau_defn::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int TDst  = TDST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_v,
  input  logic [SIMD*TDstI-1:0] in_simd,
  output logic                  s1_v,
  output logic [TDst-1:0]       s1_sum
);

  // The tree is summed at its exact growth width, then sign-extended to TDst,
  // so no intermediate can overflow before reaching the accumulator.
  localparam int SUM_W = TDstI + tree_growth(SIMD);

  logic signed [TDstI-1:0] lane;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum  = '0;
    lane = '0;
    for (int i = 0; i < SIMD; i++) begin
      lane = in_simd[i*TDstI +: TDstI];
      sum  = sum + SUM_W'(lane);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
    end else if (en) begin
      s1_v   <= in_v;
      s1_sum <= TDst'(sum);
    end
  end

endmodule

// File: rtl/mvu_pe_acc.sv
// rtl/mvu_pe_acc.sv - accumulation stage of a matrix-vector PE
// Purpose: reduces each SIMD beat, accumulates SF beats, presents the dot product
//   with valid/ready backpressure. Arithmetic wraps modulo 2^TDst.
// Ports: clk, rst (sync, active-high), bus (slave side of mvu_pe_acc_if).
module mvu_pe_acc
  import mvau_defn::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int SF    = SF_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int TDst  = TDST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mvu_pe_acc_if.slave bus
);

  localparam int               CNT_W    = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SF - 1);

  logic             en;
  logic             s1_v;
  logic [TDst-1:0]  s1_sum;
  logic [TDst-1:0]  acc;
  logic [TDst-1:0]  out_q;
  logic             out_v_q;
  logic [CNT_W-1:0] sf_cnt;

  // The whole pipeline advances only when the output register can take or
  // has handed off its result; this single enable is also the input ready.
  assign en          = !out_v_q || bus.out_rdy;
  assign bus.in_rdy  = en;
  assign bus.out_v   = out_v_q;
  assign bus.out     = out_q;

  mvu_pe_adders #(
    .SIMD  (SIMD),
    .TDstI (TDstI),
    .TDst  (TDst)
  ) u_adders (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in_v    (bus.in_v),
    .in_simd (bus.in_simd),
    .s1_v    (s1_v),
    .s1_sum  (s1_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sf_cnt  <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      // A handed-off result drops valid; a fresh load below overrides this.
      if (out_v_q && bus.out_rdy) begin
        out_v_q <= 1'b0;
      end
      if (en && s1_v) begin
        if (sf_cnt == CNT_LAST) begin
          out_q   <= acc + s1_sum;
          out_v_q <= 1'b1;
          acc     <= '0;
          sf_cnt  <= '0;
        end else begin
          acc     <= acc + s1_sum;
          sf_cnt  <= sf_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// tb/tb_mvu_pe_acc.sv - scoreboard bench for mvu_pe_acc
module tb_mvu_pe_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mvu_pe_acc_if #(.SIMD(4), .TDstI(4), .TDst(16)) b  ();
  mvu_pe_acc_if #(.SIMD(4), .TDstI(4), .TDst(6))  b6 ();

  mvu_pe_acc #(.SIMD(4), .SF(3), .TDstI(4), .TDst(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  mvu_pe_acc #(.SIMD(4), .SF(3), .TDstI(4), .TDst(6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (b6)
  );

  // The narrow instance sees exactly the same stimulus.
  assign b6.in_v    = b.in_v;
  assign b6.in_simd = b.in_simd;
  assign b6.out_rdy = b.out_rdy;

  logic [15:0] q16[$];
  logic [5:0]  q6[$];
  int          res_cyc[$];
  int          acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a result is consumed on every cycle where out_v && out_rdy.
  always @(negedge clk) begin
    if (!rst && b.out_v && b.out_rdy) begin
      if (q16.size() == 0) chk("unexpected_out16", 32'(b.out), 32'hdead);
      else chk("out16", 32'(b.out), 32'(q16.pop_front()));
      res_cyc.push_back(cyc);
    end
    if (!rst && b6.out_v && b6.out_rdy) begin
      if (q6.size() == 0) chk("unexpected_out6", 32'(b6.out), 32'hdead);
      else chk("out6", 32'(b6.out), 32'(q6.pop_front()));
    end
  end

  function automatic logic [15:0] pk(input int a, input int bb, input int c, input int d);
    logic [3:0] la, lb, lc, ld;
    la = a[3:0]; lb = bb[3:0]; lc = c[3:0]; ld = d[3:0];
    return {ld, lc, lb, la};
  endfunction

  task automatic send_beat(input logic [15:0] v);
    int tries;
    tries = 0;
    b.in_v    = 1'b1;
    b.in_simd = v;
    forever begin
      @(negedge clk);
      if (b.in_rdy) break;
      tries++;
      if (tries > 50) begin
        chk("beat_accept_timeout", 32'(tries), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    acc_cyc   = cyc;
    b.in_v    = 1'b0;
    b.in_simd = '0;
  endtask

  task automatic idle(input int n);
    b.in_v = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_res(input logic [15:0] e16, input logic [5:0] e6);
    q16.push_back(e16);
    q6.push_back(e6);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q6.size() != 0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) chk("drain_timeout", 32'(q16.size()), 32'd0);
    idle(3);
  endtask

  initial begin
    b.in_v    = 1'b0;
    b.in_simd = '0;
    b.out_rdy = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_v", 32'(b.out_v), 32'd0);
    chk("reset_out", 32'(b.out), 32'd0);
    chk("reset_in_rdy", 32'(b.in_rdy), 32'd1);
    @(posedge clk); #1;

    // Basic fold: 10 + (-4) + (-1) = 5
    res_cyc.delete();
    send_beat(pk(1, 2, 3, 4));
    send_beat(pk(-1, -1, -1, -1));
    expect_res(16'd5, 6'd5);
    send_beat(pk(7, 0, 0, -8));
    drain();
    chk("basic_count", 32'(res_cyc.size()), 32'd1);
    if (res_cyc.size() == 1) chk("basic_latency", 32'(res_cyc[0] - acc_cyc), 32'd1);

    // Bubbles between fold beats
    res_cyc.delete();
    send_beat(pk(1, 2, 3, 4));
    idle(2);
    send_beat(pk(-1, -1, -1, -1));
    idle(2);
    expect_res(16'd5, 6'd5);
    send_beat(pk(7, 0, 0, -8));
    drain();
    chk("bubble_count", 32'(res_cyc.size()), 32'd1);
    if (res_cyc.size() == 1) chk("bubble_latency", 32'(res_cyc[0] - acc_cyc), 32'd1);

    // Backpressure: result held while a beat waits on in_v
    b.out_rdy = 1'b0;
    send_beat(pk(1, 2, 3, 4));
    send_beat(pk(-1, -1, -1, -1));
    expect_res(16'd5, 6'd5);
    send_beat(pk(7, 0, 0, -8));
    idle(1);
    b.in_v    = 1'b1;
    b.in_simd = pk(1, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_out_v", 32'(b.out_v), 32'd1);
      chk("stall_out", 32'(b.out), 32'd5);
      chk("stall_in_rdy", 32'(b.in_rdy), 32'd0);
      @(posedge clk); #1;
    end
    b.out_rdy = 1'b1;
    @(negedge clk);
    chk("release_in_rdy", 32'(b.in_rdy), 32'd1);
    @(posedge clk); #1;
    b.in_v = 1'b0;
    send_beat(pk(1, 1, 1, 1));
    expect_res(16'd12, 6'd12);
    send_beat(pk(1, 1, 1, 1));
    drain();

    // Back-to-back: two results of 12, three cycles apart
    res_cyc.delete();
    for (int k = 0; k < 6; k++) begin
      if (k == 2 || k == 5) expect_res(16'd12, 6'd12);
      send_beat(pk(1, 1, 1, 1));
    end
    drain();
    chk("b2b_count", 32'(res_cyc.size()), 32'd2);
    if (res_cyc.size() == 2) chk("b2b_spacing", 32'(res_cyc[1] - res_cyc[0]), 32'd3);

    // Overflow: 3 * (-32) = -96 -> 0xFFA0; wraps to 32 at 6 bits
    send_beat(pk(-8, -8, -8, -8));
    send_beat(pk(-8, -8, -8, -8));
    expect_res(16'hFFA0, 6'd32);
    send_beat(pk(-8, -8, -8, -8));
    drain();

    // Reset mid-fold discards the partial sum
    send_beat(pk(1, 1, 1, 1));
    send_beat(pk(1, 1, 1, 1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_during_out_v", 32'(b.out_v), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_out_v", 32'(b.out_v), 32'd0);
    chk("rst_after_in_rdy", 32'(b.in_rdy), 32'd1);
    @(posedge clk); #1;
    res_cyc.delete();
    send_beat(pk(2, 2, 2, 2));
    send_beat(pk(2, 2, 2, 2));
    expect_res(16'd24, 6'd24);
    send_beat(pk(2, 2, 2, 2));
    drain();
    chk("rst_result_count", 32'(res_cyc.size()), 32'd1);

    chk("final_queue16", 32'(q16.size()), 32'd0);
    chk("final_queue6", 32'(q6.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mvu_pe_acc.md
# mvu_pe_acc

Accumulation stage of a matrix-vector PE. It sits directly downstream of the PE's SIMD multiplier lanes and consumes one beat per cycle: SIMD signed products of TDstI bits each. A registered adder tree reduces each beat to one partial sum, which is accumulated over SF beats (the synapse fold). The completed dot product is presented as a TDst-bit output with valid/ready backpressure.

## Interface
- SIMD, 4: number of product lanes per beat (≥1)
- SF, 3: beats per output (synapse fold, ≥1)
- TDstI, 4: width of each signed product lane
- TDst, 16: accumulator/output width; must satisfy TDst ≥ TDstI+$clog2(SIMD)
- clk  in  1  main clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_v  in  1  input beat valid
- in_rdy  out  1  block can accept a beat this cycle
- in_simd  in  SIMD*TDstI  packed products, lane i at [i*TDstI +: TDstI], two's complement
- out_v  out  1  result valid
- out_rdy  in  1  downstream accepts result
- out  out  TDst  accumulated dot product, two's complement

## Operation
- Global enable: en = !out_v || out_rdy; in_rdy = en (combinational). A beat is accepted when in_v && in_rdy.
- Stage 1 (adder tree), updates only when en: sign-extend each lane to TDst and sum all lanes into s1_sum; s1_v <= in_v. When !en, s1_sum and s1_v hold.
- Stage 2 (accumulate), acts when en && s1_v:
  - sf_cnt counts 0..SF-1.
  - If sf_cnt < SF-1: acc <= acc + s1_sum; sf_cnt++.
  - If sf_cnt == SF-1: out <= acc + s1_sum; out_v <= 1; acc <= 0; sf_cnt <= 0.
- out_v clears when out_rdy && out_v, unless a new result loads in the same cycle; in that case it stays 1 and out takes the new value.
- Arithmetic is modulo 2^TDst. Overflow wraps silently; no saturation or flag.
- SF == 1: every beat yields one result and acc stays 0.
- Bubbles (in_v = 0) do not advance sf_cnt; fold beats may be non-contiguous.

Reset values (rst = 1 on a clock edge):
- out_v = 0, out = 0, s1_v = 0, s1_sum = 0, acc = 0, sf_cnt = 0.
- Reset mid-fold discards the partial accumulation and any result still held.
- in_rdy = 1 in the cycle after reset.

## Timing
- Latency: the final fold beat accepted on edge E gives out_v = 1 after edge E+1, i.e. 2 edges from acceptance to valid.
- Throughput: one beat per cycle while out_rdy = 1. With SF = 1, one result per cycle.
- Stall: while out_v && !out_rdy:
  - in_rdy = 0.
  - stage 1 and stage 2 freeze.
  - out is held stable.
- No combinational path from in_v or in_simd to out or out_v. Only out_v and out_rdy feed in_rdy combinationally.

## Structure
- Shared mvau_defn package: default widths (SIMD, SF, TDstI, TDst) and a function computing the adder-tree growth width $clog2(SIMD).
- Sub-module mvu_pe_adders: registered, parameterised signed reduction of SIMD lanes to TDst, with enable input; 1-cycle latency.
- The top level holds the fold counter, accumulator, output register and handshake logic.

## Test plan
All scenarios use defaults (SIMD=4, SF=3, TDstI=4, TDst=16).
- Basic fold: three contiguous beats, lanes {1,2,3,4}, {−1,−1,−1,−1}, {7,0,0,−8}, with out_rdy = 1 → one result out = 5, out_v high for exactly 1 cycle, 2 edges after the third beat.
- Bubbles: the same three beats separated by 2 idle cycles each → out = 5, with no extra or early out_v.
- Backpressure:
  - Hold out_rdy = 0 when the result appears → out = 5 held stable and in_rdy = 0 for 4 cycles, with a beat held on in_v.
  - Release out_rdy → the held beat is accepted in that cycle and the next fold computes correctly.
- Back-to-back: six beats, all lanes = 1, out_rdy = 1 → two results, both 12, exactly 3 cycles apart.
- Overflow: three beats of all lanes = −8 → out = −96 (0xFFA0). Also test with TDst = 6 parameterisation, where the value wraps to 32.
- Reset mid-fold: two beats of all lanes = 1, then assert rst for 1 cycle, then three beats of all lanes = 2 → single result out = 24; out_v = 0 during and immediately after reset.
